// File: rtl/tpu_result_deskew_if.sv
// Result-side bus of the TPU deskew collector: skewed lanes in, packed matrix out.
// slave is the collector's view; master is the producer/consumer side.
interface tpu_result_deskew_if #(
    parameter int unsigned MATRIX_SIZE = 4,
    parameter int unsigned ACC_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH   = 8
);
    logic                                           start;
    logic [MATRIX_SIZE-1:0][ACC_WIDTH-1:0]          tpu_outarray;
    logic [MATRIX_SIZE*MATRIX_SIZE*OUT_WIDTH-1:0]   flattened_result_output;
    logic                                           result_valid;
    logic                                           result_ready;
    logic                                           busy;
    logic                                           done_deskew;

    modport slave (
        input  start, tpu_outarray, result_ready,
        output flattened_result_output, result_valid, busy, done_deskew
    );

    modport master (
        output start, tpu_outarray, result_ready,
        input  flattened_result_output, result_valid, busy, done_deskew
    );
endinterface

// File: rtl/tpu_result_deskew.sv
// Collects diagonally skewed TPU result lanes, removes the skew and packs the matrix row-major.
// Define SATURATE_EN for signed saturation on narrowing; otherwise results are truncated.
module tpu_result_deskew #(
    parameter int unsigned MATRIX_SIZE = 4,
    parameter int unsigned ACC_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH   = 8
) (
    input logic                 clk,
    input logic                 rst,
    tpu_result_deskew_if.slave  bus
);
    localparam int unsigned N      = MATRIX_SIZE;
    localparam int unsigned LAST_K = 2 * N - 2;
    localparam int unsigned CNT_W  = (2 * N - 1 > 1) ? $clog2(2 * N - 1) : 1;
    localparam int unsigned IDX_W  = (N * N > 1) ? $clog2(N * N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_K);

`ifdef SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HOLD
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [N*N-1:0][OUT_WIDTH-1:0]   result_q, result_d;
    logic                            valid_q, valid_d;
    logic                            done_q, done_d;
    logic [31:0]                     cnt_ext;

    function automatic logic [OUT_WIDTH-1:0] narrow(input logic [ACC_WIDTH-1:0] v);
`ifdef SATURATE_EN
        if ($signed(v) > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
        if ($signed(v) < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        return v[OUT_WIDTH-1:0];
`else
        logic unused_hi;
        unused_hi = ^v[ACC_WIDTH-1:OUT_WIDTH];
        return v[OUT_WIDTH-1:0];
`endif
    endfunction

    assign cnt_ext = 32'(cnt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    result_d[N*N-1] = narrow(bus.tpu_outarray[0]);
                    cnt_d           = CNT_W'(1);
                    state_d         = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Lane j carries row cnt-j this cycle; element (i,j) lives at index N*N-1-(i*N+j).
                for (int unsigned j = 0; j < N; j++) begin
                    if ((cnt_ext >= j) && ((cnt_ext - j) < N)) begin
                        result_d[IDX_W'(N * N - 1 - ((cnt_ext - j) * N + j))] =
                            narrow(bus.tpu_outarray[j]);
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.result_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.flattened_result_output = result_q;
    assign bus.result_valid            = valid_q;
    assign bus.done_deskew             = done_q;
    assign bus.busy                    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_tpu_result_deskew.sv
// Directed bench for tpu_result_deskew (N=4, ACC_WIDTH=16, OUT_WIDTH=8).
module tb_tpu_result_deskew;
    localparam int N = 4;
    localparam logic [127:0] EXP_A = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] EXP_B = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tpu_result_deskew_if #(.MATRIX_SIZE(4), .ACC_WIDTH(16), .OUT_WIDTH(8)) bus ();

    tpu_result_deskew #(.MATRIX_SIZE(4), .ACC_WIDTH(16), .OUT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] mat [N][N];

    task automatic load_a();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mat[i][j] = 16'(4 * i + j + 1);
    endtask

    task automatic load_b();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mat[i][j] = 16'hFFA0 + 16'(4 * i + j);
    endtask

    task automatic drive_lanes(input int k, input logic [15:0] fill);
        for (int j = 0; j < N; j++) begin
            if ((k - j >= 0) && (k - j < N)) bus.tpu_outarray[j] = mat[k-j][j];
            else bus.tpu_outarray[j] = fill;
        end
    endtask

    // Feeds one skewed matrix from an IDLE cycle; reports the cycle result_valid rose and done pulses.
    task automatic feed(input logic [15:0] fill, output int rise, output int dones);
        rise  = -1;
        dones = 0;
        for (int k = 0; k < 2 * N - 1; k++) begin
            bus.start = (k == 0);
            drive_lanes(k, fill);
            @(posedge clk); #1;
            if (bus.result_valid && rise < 0) rise = k + 1;
            if (bus.done_deskew) dones++;
        end
        bus.start = 1'b0;
        for (int j = 0; j < N; j++) bus.tpu_outarray[j] = fill;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        for (int j = 0; j < N; j++) bus.tpu_outarray[j] = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.result_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done_deskew !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done_deskew); end
        total++; if (bus.flattened_result_output !== 128'h0) begin bad++; $display("FAIL rst_flat got=%h exp=0", bus.flattened_result_output); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic handshake(input string tag);
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL %s_hs_valid got=%b exp=0", tag, bus.result_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_hs_busy got=%b exp=0", tag, bus.busy); end
    endtask

    task automatic test_basic();
        int rise, dones;
        load_a();
        feed(16'h0000, rise, dones);
        total++; if (rise !== 7) begin bad++; $display("FAIL t1_latency got=%0d exp=7", rise); end
        total++; if (dones !== 1) begin bad++; $display("FAIL t1_done_count got=%0d exp=1", dones); end
        total++; if (bus.flattened_result_output !== EXP_A) begin bad++; $display("FAIL t1_flat got=%h exp=%h", bus.flattened_result_output, EXP_A); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", bus.busy); end
        @(posedge clk); #1;
        total++; if (bus.done_deskew !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%b exp=0", bus.done_deskew); end
        total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL t1_valid_hold got=%b exp=1", bus.result_valid); end
        handshake("t1");
        @(posedge clk); #1;
    endtask

    task automatic test_garbage();
        int rise, dones;
        load_a();
        feed(16'hFFFF, rise, dones);
        total++; if (rise !== 7) begin bad++; $display("FAIL t2_latency got=%0d exp=7", rise); end
        total++; if (dones !== 1) begin bad++; $display("FAIL t2_done_count got=%0d exp=1", dones); end
        total++; if (bus.flattened_result_output !== EXP_A) begin bad++; $display("FAIL t2_flat got=%h exp=%h", bus.flattened_result_output, EXP_A); end
        handshake("t2");
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int rise, dones;
        load_a();
        feed(16'h0000, rise, dones);
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 2);
            for (int j = 0; j < N; j++) bus.tpu_outarray[j] = 16'h5A5A;
            @(posedge clk); #1;
            total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL t3_valid c=%0d got=%b exp=1", c, bus.result_valid); end
            total++; if (bus.flattened_result_output !== EXP_A) begin bad++; $display("FAIL t3_flat c=%0d got=%h exp=%h", c, bus.flattened_result_output, EXP_A); end
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL t3_busy c=%0d got=%b exp=1", c, bus.busy); end
        end
        bus.start = 1'b0;
        handshake("t3");
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t3_idle_after got=%b exp=0", bus.busy); end
    endtask

    task automatic test_narrow();
        int rise, dones;
        logic [127:0] exp_w;
        logic [7:0] e00, e11;
`ifdef SATURATE_EN
        e00 = 8'h7F;
        e11 = 8'h80;
`else
        e00 = 8'h00;
        e11 = 8'hD4;
`endif
        load_a();
        mat[0][0] = 16'h0200;
        mat[1][1] = 16'hFED4;
        mat[2][2] = 16'hFFF0;
        exp_w = EXP_A;
        exp_w[127-:8]  = e00;
        exp_w[80+:8]   = e11;
        exp_w[40+:8]   = 8'hF0;
        feed(16'h0000, rise, dones);
        total++; if (bus.flattened_result_output[127-:8] !== e00) begin bad++; $display("FAIL t4_c00 got=%h exp=%h", bus.flattened_result_output[127-:8], e00); end
        total++; if (bus.flattened_result_output[80+:8] !== e11) begin bad++; $display("FAIL t4_c11 got=%h exp=%h", bus.flattened_result_output[80+:8], e11); end
        total++; if (bus.flattened_result_output !== exp_w) begin bad++; $display("FAIL t4_flat got=%h exp=%h", bus.flattened_result_output, exp_w); end
        handshake("t4");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int rise, dones;
        load_a();
        for (int k = 0; k < 4; k++) begin
            bus.start = (k == 0);
            drive_lanes(k, 16'h0000);
            rst = (k == 3);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t5_busy got=%b exp=0", bus.busy); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL t5_valid got=%b exp=0", bus.result_valid); end
        total++; if (bus.done_deskew !== 1'b0) begin bad++; $display("FAIL t5_done got=%b exp=0", bus.done_deskew); end
        total++; if (bus.flattened_result_output !== 128'h0) begin bad++; $display("FAIL t5_flat_clr got=%h exp=0", bus.flattened_result_output); end
        load_b();
        feed(16'h1234, rise, dones);
        total++; if (rise !== 7) begin bad++; $display("FAIL t5_latency got=%0d exp=7", rise); end
        total++; if (bus.flattened_result_output !== EXP_B) begin bad++; $display("FAIL t5_flat got=%h exp=%h", bus.flattened_result_output, EXP_B); end
        handshake("t5");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int rise, dones;
        bus.result_ready = 1'b1;
        load_a();
        feed(16'h0000, rise, dones);
        total++; if (rise !== 7) begin bad++; $display("FAIL t6_a_latency got=%0d exp=7", rise); end
        total++; if (bus.flattened_result_output !== EXP_A) begin bad++; $display("FAIL t6_a_flat got=%h exp=%h", bus.flattened_result_output, EXP_A); end
        @(posedge clk); #1;
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL t6_gap_valid got=%b exp=0", bus.result_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t6_gap_busy got=%b exp=0", bus.busy); end
        load_b();
        feed(16'hFFFF, rise, dones);
        total++; if (rise !== 7) begin bad++; $display("FAIL t6_b_latency got=%0d exp=7", rise); end
        total++; if (dones !== 1) begin bad++; $display("FAIL t6_b_done_count got=%0d exp=1", dones); end
        total++; if (bus.flattened_result_output !== EXP_B) begin bad++; $display("FAIL t6_b_flat got=%h exp=%h", bus.flattened_result_output, EXP_B); end
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL t6_b_hs_valid got=%b exp=0", bus.result_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_garbage();
        test_hold();
        test_narrow();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
